// File: rtl/cordic_operand_injector.sv
// Clocked-to-async operand injector: single-rail host operand in, dual-rail
// four-phase RTZ codeword out to the async square-root operand join.

package pa_AsyncCordic;
  localparam int RW = 15;
  localparam int EW = 7;
  // {t,f}: 10 = one, 01 = zero, 00 = spacer, 11 illegal
  typedef struct packed {
    logic t;
    logic f;
  } dual_rail_t;
endpackage

// One dual-rail bit; both rails come straight off flops so the async side
// never sees combinational glitches.
module dr_rail_flop (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      load,
  input  logic                      clear,
  input  logic                      d,
  output pa_AsyncCordic::dual_rail_t q
);
  always_ff @(posedge clk or posedge rst) begin
    if (rst)        q <= '0;
    else if (load)  q <= '{t: d, f: ~d};
    else if (clear) q <= '0;
  end
endmodule

// Plain flop chain for an asynchronous ack; STAGES must be at least 2.
module ack_sync_chain #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);
  logic [STAGES-1:0] chain;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) chain <= '0;
    else     chain <= {chain[STAGES-2:0], d};
  end

  assign q = chain[STAGES-1];
endmodule

module cordic_operand_injector #(
  parameter int RW          = pa_AsyncCordic::RW,
  parameter int EW          = pa_AsyncCordic::EW,
  parameter int SYNC_STAGES = 2,
  parameter int TIMEOUT     = 1024
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             op_valid,
  output logic                             op_ready,
  input  logic [RW:0]                      op_radicand,
  input  logic [EW:0]                      op_exp,
  output pa_AsyncCordic::dual_rail_t [RW:0] radicand,
  output pa_AsyncCordic::dual_rail_t [EW:0] exp,
  input  logic                             radicand_ack,
  input  logic                             exp_ack,
  output logic [15:0]                      xfer_cnt,
  output logic                             error
);
  typedef enum logic [1:0] {IDLE, DRIVE, RTZ} state_t;

  localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [TW-1:0] TLIM = TW'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

  state_t        state, state_d;
  logic          rad_s, exp_s;
  logic          c_q, ack_sync;
  logic          hs, load, clear, busy;
  logic          ready_d;
  logic [TW-1:0] tcnt;

  ack_sync_chain #(.STAGES(SYNC_STAGES)) u_rad_sync (
    .clk(clk), .rst(rst), .d(radicand_ack), .q(rad_s)
  );
  ack_sync_chain #(.STAGES(SYNC_STAGES)) u_exp_sync (
    .clk(clk), .rst(rst), .d(exp_ack), .q(exp_s)
  );

  // C-element: rises only when both acks are up, falls only when both are down
  assign ack_sync = (rad_s & exp_s) | (c_q & (rad_s | exp_s));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) c_q <= 1'b0;
    else     c_q <= ack_sync;
  end

  genvar i;
  generate
    for (i = 0; i <= RW; i++) begin : g_rad
      dr_rail_flop u_bit (
        .clk(clk), .rst(rst), .load(load), .clear(clear),
        .d(op_radicand[i]), .q(radicand[i])
      );
    end
    for (i = 0; i <= EW; i++) begin : g_exp
      dr_rail_flop u_bit (
        .clk(clk), .rst(rst), .load(load), .clear(clear),
        .d(op_exp[i]), .q(exp[i])
      );
    end
  endgenerate

  assign hs   = op_valid & op_ready & (state == IDLE);
  assign busy = (state == DRIVE) || (state == RTZ);

  always_comb begin
    state_d = state;
    load    = 1'b0;
    clear   = 1'b0;
    case (state)
      IDLE:  if (hs) begin
               load    = 1'b1;
               state_d = DRIVE;
             end
      DRIVE: if (ack_sync) begin
               clear   = 1'b1;
               state_d = RTZ;
             end
      RTZ:   if (!ack_sync) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Raw acks also hold off ready: right after reset the synchroniser is empty
  // and cannot yet show an ack left high by the async side.
  assign ready_d = (state == IDLE) & ~hs & ~ack_sync & ~(radicand_ack | exp_ack);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      op_ready <= 1'b0;
      xfer_cnt <= '0;
    end else begin
      state    <= state_d;
      op_ready <= ready_d;
      if (state == RTZ && state_d == IDLE) xfer_cnt <= xfer_cnt + 16'd1;
    end
  end

  // Edges spent without a state change in DRIVE/RTZ; saturates once error is set
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tcnt  <= '0;
      error <= 1'b0;
    end else if (state_d != state) begin
      tcnt <= '0;
    end else if (busy && TIMEOUT != 0) begin
      if (tcnt == TLIM) error <= 1'b1;
      else              tcnt  <= tcnt + 1'b1;
    end
  end
endmodule

// File: tb/tb_cordic_operand_injector.sv
// Bench for cordic_operand_injector: table of operands with hand-encoded rails,
// scoreboard of codewords checked as they appear on the rails.
module tb_cordic_operand_injector;
  localparam int RW = 3;
  localparam int EW = 1;
  localparam int SS = 2;

  typedef struct {
    logic [RW:0]  r;
    logic [EW:0]  e;
    logic [11:0]  rails;
  } vec_t;

  logic clk = 1'b0;
  logic rst;
  logic op_valid, op_ready;
  logic [RW:0] op_radicand;
  logic [EW:0] op_exp;
  pa_AsyncCordic::dual_rail_t [RW:0] radicand;
  pa_AsyncCordic::dual_rail_t [EW:0] exp_rails;
  logic radicand_ack, exp_ack;
  logic [15:0] xfer_cnt;
  logic error;

  logic auto_ack, man_rack, man_eack;
  logic [3:0] dly = '0;
  logic [7:0] rad_bits;
  logic [3:0] exp_bits;
  logic [11:0] cur_rails;
  logic [11:0] prev_rails = '0;

  vec_t tbl [5];
  logic [11:0] sb [$];
  int total = 0;
  int bad = 0;
  int viol = 0;

  always #5 clk = ~clk;

  cordic_operand_injector #(.RW(RW), .EW(EW), .SYNC_STAGES(SS), .TIMEOUT(16)) dut (
    .clk(clk), .rst(rst), .op_valid(op_valid), .op_ready(op_ready),
    .op_radicand(op_radicand), .op_exp(op_exp),
    .radicand(radicand), .exp(exp_rails),
    .radicand_ack(radicand_ack), .exp_ack(exp_ack),
    .xfer_cnt(xfer_cnt), .error(error)
  );

  assign rad_bits     = radicand;
  assign exp_bits     = exp_rails;
  assign cur_rails    = {rad_bits, exp_bits};
  assign radicand_ack = auto_ack ? dly[3] : man_rack;
  assign exp_ack      = auto_ack ? dly[3] : man_eack;

  // Async side stand-in: ack follows "codeword present" three edges late
  always @(posedge clk) begin
    #1;
    dly = {dly[2:0], (cur_rails != 12'd0)};
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] want);
    total++;
    if (act !== want) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, want);
    end
  endtask

  // Codeword monitor: pops the scoreboard on every spacer->codeword change
  always @(negedge clk) begin
    for (int i = 0; i < 6; i++)
      if (cur_rails[2*i +: 2] == 2'b11) viol++;
    if (cur_rails != 12'd0 && prev_rails == 12'd0) begin
      if (sb.size() == 0) check("unexpected_codeword", {20'd0, cur_rails}, 32'd0);
      else                check("codeword", {20'd0, cur_rails}, {20'd0, sb.pop_front()});
    end else if (cur_rails != 12'd0 && prev_rails != 12'd0 && cur_rails != prev_rails) begin
      viol++;
    end
    prev_rails = cur_rails;
  end

  // Returns one time unit after the handshake edge
  task automatic send(input int idx, input bit hold);
    int n;
    op_valid    = 1'b1;
    op_radicand = tbl[idx].r;
    op_exp      = tbl[idx].e;
    n = 0;
    @(negedge clk);
    while (!op_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (!op_ready) begin
      check("send_ready_wait", 32'd0, 32'd1);
      op_valid = 1'b0;
      return;
    end
    sb.push_back(tbl[idx].rails);
    @(posedge clk);
    #1;
    if (!hold) op_valid = 1'b0;
    op_radicand = RW'($urandom);
    op_exp      = EW'($urandom);
  endtask

  task automatic wait_ready(input string name);
    int n;
    n = 0;
    while (!op_ready && n < 100) begin
      @(posedge clk);
      #1;
      n++;
    end
    check(name, {31'd0, op_ready}, 32'd1);
  endtask

  task automatic wait_spacer(input string name, output int n);
    n = 0;
    do begin
      @(posedge clk);
      #1;
      n++;
    end while (cur_rails != 12'd0 && n < 40);
    check(name, {20'd0, cur_rails}, 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int n;
    int first;
    bit seen;

    tbl[0] = '{r: 4'b1010, e: 2'b01, rails: {8'b10_01_10_01, 4'b01_10}};
    tbl[1] = '{r: 4'b0000, e: 2'b00, rails: {8'b01_01_01_01, 4'b01_01}};
    tbl[2] = '{r: 4'b1111, e: 2'b11, rails: {8'b10_10_10_10, 4'b10_10}};
    tbl[3] = '{r: 4'b0110, e: 2'b10, rails: {8'b01_10_10_01, 4'b10_01}};
    tbl[4] = '{r: 4'b1001, e: 2'b11, rails: {8'b10_01_01_10, 4'b10_10}};

    rst = 1'b1; op_valid = 1'b0; op_radicand = '0; op_exp = '0;
    auto_ack = 1'b1; man_rack = 1'b0; man_eack = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_ready", {31'd0, op_ready}, 32'd0);
    check("rst_rails", {20'd0, cur_rails}, 32'd0);
    check("rst_xfer", {16'd0, xfer_cnt}, 32'd0);
    check("rst_error", {31'd0, error}, 32'd0);
    rst = 1'b0;
    @(posedge clk);
    #1;
    check("first_ready", {31'd0, op_ready}, 32'd1);

    // Single transfer, loopback delay 3 on both ack edges: 7 + 6 edges to ready
    send(0, 1'b0);
    n = 0;
    do begin
      @(posedge clk);
      #1;
      n++;
    end while (!op_ready && n < 40);
    check("ready_return_edges", n, 13);
    check("xfer_after_first", {16'd0, xfer_cnt}, 32'd1);

    // Back-to-back with op_valid held
    for (int i = 1; i <= 4; i++) send(i, i < 4);
    wait_ready("b2b_ready");
    check("b2b_xfer", {16'd0, xfer_cnt}, 32'd5);
    check("b2b_sb_empty", sb.size(), 32'd0);

    // Stale ack held across reset release
    auto_ack = 1'b0; man_rack = 1'b1; man_eack = 1'b1;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    seen = 1'b0;
    repeat (6) begin
      @(negedge clk);
      if (op_ready) seen = 1'b1;
    end
    check("stale_ready_held", {31'd0, seen}, 32'd0);
    man_rack = 1'b0; man_eack = 1'b0;
    n = 0;
    do begin
      @(posedge clk);
      #1;
      n++;
    end while (!op_ready && n < 20);
    check("stale_release_edges", n, SS + 1);

    // Split ack: radicand alone does not complete the phase
    send(3, 1'b0);
    man_rack = 1'b1;
    repeat (10) @(posedge clk);
    #1;
    check("split_rails_hold", {20'd0, cur_rails}, {20'd0, tbl[3].rails});
    man_eack = 1'b1;
    wait_spacer("split_spacer", n);
    check("split_spacer_edges", n, SS + 1);
    man_rack = 1'b0; man_eack = 1'b0;
    wait_ready("split_ready");
    check("split_xfer", {16'd0, xfer_cnt}, 32'd1);
    check("split_no_error", {31'd0, error}, 32'd0);

    // Reset in DRIVE, asserted between edges
    send(2, 1'b0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    #2;
    rst = 1'b1;
    #1;
    check("midrst_rails", {20'd0, cur_rails}, 32'd0);
    check("midrst_ready", {31'd0, op_ready}, 32'd0);
    check("midrst_xfer", {16'd0, xfer_cnt}, 32'd0);
    check("midrst_error", {31'd0, error}, 32'd0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    wait_ready("midrst_ready_after");

    // Timeout with acks held low, then late completion
    send(4, 1'b0);
    first = 0;
    for (int k = 1; k <= 20; k++) begin
      @(posedge clk);
      #1;
      if (error && first == 0) first = k;
    end
    check("timeout_edge", first, 16);
    man_rack = 1'b1; man_eack = 1'b1;
    wait_spacer("timeout_spacer", n);
    man_rack = 1'b0; man_eack = 1'b0;
    wait_ready("timeout_ready");
    check("timeout_xfer", {16'd0, xfer_cnt}, 32'd1);
    check("timeout_error_sticky", {31'd0, error}, 32'd1);

    repeat (2) @(posedge clk);
    check("rail_integrity", viol, 0);
    check("sb_empty", sb.size(), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/cordic_operand_injector.md
Name: cordic_operand_injector

Overview:
- Clocked front end of the async square-root unit.
- Accepts a single-rail operand (radicand, exponent) from the synchronous host with a valid/ready handshake.
- Encodes it to dual-rail and drives it into the async operand join using a four-phase return-to-zero protocol.
- Only clocked-to-async boundary on the input side; the ack returning from the async pipeline is synchronised here.

Parameters:
- RW, pa_AsyncCordic::RW: radicand MSB index; radicand is RW+1 bits.
- EW, pa_AsyncCordic::EW: exponent MSB index; exponent is EW+1 bits.
- SYNC_STAGES, 2: flops in the ack synchroniser, minimum 2.
- TIMEOUT, 1024: cycles allowed in DRIVE or RTZ before error; 0 disables.

Ports:
- clk  in  1  single clock.
- rst  in  1  asynchronous, active-high reset.
- op_valid  in  1  host operand valid.
- op_ready  out  1  block can accept an operand.
- op_radicand  in  RW+1  single-rail radicand.
- op_exp  in  EW+1  single-rail exponent.
- radicand  out  pa_AsyncCordic::dual_rail_t[RW:0]  dual-rail radicand to the operand join.
- exp  out  pa_AsyncCordic::dual_rail_t[EW:0]  dual-rail exponent to the operand join.
- radicand_ack  in  1  async ack for radicand.
- exp_ack  in  1  async ack for exponent.
- xfer_cnt  out  16  completed four-phase transfers, wraps.
- error  out  1  sticky ack timeout flag.

Behaviour:
- Encoding per bit, rails {t,f}:
  - logic 1 = 2'b10, logic 0 = 2'b01.
  - spacer = 2'b00; 2'b11 is never driven.
- Every rail is driven directly from its own flop; no logic between flop and port (hazard-free toward async logic).
- Ack combine: ack_raw = radicand_ack & exp_ack for the rising phase and radicand_ack | exp_ack for the falling phase, i.e. both must rise and both must fall. The combine is implemented as a Muller C-element equivalent on the synchronised values. ack_sync is the SYNC_STAGES-deep synchronised result.
- Reset (async assert, sync release):
  - state IDLE; all rails spacer; op_ready 0; xfer_cnt 0; error 0; synchroniser cleared.
- FSM:
  - IDLE: rails spacer. Handshake = op_valid & op_ready at an edge. On handshake, the encoded operand is registered onto the rails at that same edge and the state goes to DRIVE.
  - DRIVE: rails hold the codeword. When ack_sync=1 at an edge, rails go to spacer at that edge and the state goes to RTZ.
  - RTZ: rails spacer. When ack_sync=0 at an edge, the state goes to IDLE and xfer_cnt increments (wraps 16'hFFFF to 0).
- op_ready is a registered output. It is loaded with 1 at an edge where the state is and stays IDLE, ack_sync=0 and no handshake occurs; otherwise it is loaded with 0.
  - First op_ready=1 is one edge after reset release.
  - op_ready never asserts while ack_sync=1 in IDLE (stale ack from the async side).
- Host data is sampled only at the handshake edge. Changes on op_* at other times have no effect.
- Minimum cycles per operand, with an async side that acks instantly: 1 (capture) + SYNC_STAGES + 1 (spacer) + SYNC_STAGES + 1 (ready) = 2*SYNC_STAGES+3.
- Timeout:
  - The counter resets on every state change and counts edges spent in DRIVE or RTZ.
  - Reaching TIMEOUT sets error. The FSM stays in its state and still completes if ack eventually arrives.
  - error clears only on rst.
- Reset mid-transfer: rails return to spacer immediately (asynchronous) and the state is IDLE. The async side must then drop ack, and op_ready stays 0 until ack_sync=0.
- Only one ack input risen: treated as not acked; the block stays in DRIVE.

Test Plan:
- RW=3, EW=1, acks looped back through a 3-cycle delay: send radicand 4'b1010, exp 2'b01 -> rails 8'b10_01_10_01 and 4'b01_10 during DRIVE; then all zero; xfer_cnt=1; op_ready returns after 2*SYNC_STAGES+3 edges plus loop delay.
- Back-to-back: op_valid held high with 4 operands -> each encoded in order, spacer between every codeword, xfer_cnt=4, no 2'b11 rail pair ever observed.
- Stale ack: radicand_ack=exp_ack=1 at reset release -> op_ready stays 0 until both drop, then rises after SYNC_STAGES+1 edges.
- Split ack: only radicand_ack rises -> state stays DRIVE, rails unchanged. exp_ack rises 10 cycles later -> spacer SYNC_STAGES+1 edges after that.
- Timeout: TIMEOUT=16, acks held 0 -> error=1 at the 16th edge in DRIVE; acks then toggled -> transfer completes, xfer_cnt=1, error stays 1.
- Reset asserted in DRIVE -> rails spacer with no clock edge; error=0, xfer_cnt=0, op_ready=0 during reset.
